// File: rtl/wb_copy_pkg.sv
// Shared types and constants for the Wishbone word-copy engine.
package wb_copy_pkg;

  // Copy sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_RD_GAP = 3'd2,
    ST_WR     = 3'd3,
    ST_WR_GAP = 3'd4,
    ST_FIN    = 3'd5
  } state_t;

  // Cycles an access may wait for ack/err/rty before it is abandoned
  localparam int TIMEOUT_DEFAULT = 16;

  // Full 32-bit word lanes
  localparam logic [3:0] SEL_ALL = 4'hF;

endpackage : wb_copy_pkg

// File: rtl/wb_copy_engine.sv
// Wishbone master that copies len 32-bit words from src_adr to dst_adr,
// one read then one write per word, with a one-cycle idle gap between
// strobes. Retries are reissued unchanged; err or a response timeout
// aborts the copy and raises error until the next start.
module wb_copy_engine
  import wb_copy_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int LEN_W   = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      src_adr,
  input  logic [31:0]      dst_adr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  output logic [3:0]       wbm_sel_o,
  output logic             wbm_we_o,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  input  logic [31:0]      wbm_dat_i,
  input  logic             wbm_ack_i,
  input  logic             wbm_err_i,
  input  logic             wbm_rty_i
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  // Value of the wait counter during the last permitted wait cycle
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  // Sequencer state and datapath registers
  state_t             state_reg, state_next;
  logic [31:0]        src_reg, src_next;
  logic [31:0]        dst_reg, dst_next;
  logic [LEN_W-1:0]   cnt_reg, cnt_next;
  logic [31:0]        data_reg, data_next;
  logic [TMO_W-1:0]   tmo_reg, tmo_next;
  logic               retry_reg, retry_next;
  logic               error_reg, error_next;

  // Registered bus and status outputs
  logic [31:0]        adr_reg, adr_next;
  logic [31:0]        dat_reg, dat_next;
  logic [3:0]         sel_reg, sel_next;
  logic               we_reg, we_next;
  logic               cyc_reg, cyc_next;
  logic               stb_reg, stb_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;

  // A response only counts while a strobe is actually on the bus
  logic               rsp_err, rsp_ack, rsp_rty;

  assign rsp_err = stb_reg & wbm_err_i;
  assign rsp_ack = stb_reg & ~wbm_err_i & wbm_ack_i;
  assign rsp_rty = stb_reg & ~wbm_err_i & ~wbm_ack_i & wbm_rty_i;

  // State and output registers; reset clears everything immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      src_reg   <= '0;
      dst_reg   <= '0;
      cnt_reg   <= '0;
      data_reg  <= '0;
      tmo_reg   <= '0;
      retry_reg <= 1'b0;
      error_reg <= 1'b0;
      adr_reg   <= '0;
      dat_reg   <= '0;
      sel_reg   <= '0;
      we_reg    <= 1'b0;
      cyc_reg   <= 1'b0;
      stb_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      src_reg   <= src_next;
      dst_reg   <= dst_next;
      cnt_reg   <= cnt_next;
      data_reg  <= data_next;
      tmo_reg   <= tmo_next;
      retry_reg <= retry_next;
      error_reg <= error_next;
      adr_reg   <= adr_next;
      dat_reg   <= dat_next;
      sel_reg   <= sel_next;
      we_reg    <= we_next;
      cyc_reg   <= cyc_next;
      stb_reg   <= stb_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  // Next-state and datapath updates; response priority is err > ack > rty
  always_comb begin
    state_next = state_reg;
    src_next   = src_reg;
    dst_next   = dst_reg;
    cnt_next   = cnt_reg;
    data_next  = data_reg;
    tmo_next   = tmo_reg;
    retry_next = retry_reg;
    error_next = error_reg;

    unique case (state_reg)
      ST_IDLE: begin
        if (start) begin
          error_next = 1'b0;
          if (len != '0) begin
            src_next   = src_adr;
            dst_next   = dst_adr;
            cnt_next   = len;
            tmo_next   = '0;
            retry_next = 1'b0;
            state_next = ST_RD;
          end else begin
            state_next = ST_FIN;
          end
        end
      end

      ST_RD: begin
        if (rsp_err) begin
          error_next = 1'b1;
          state_next = ST_FIN;
        end else if (rsp_ack) begin
          data_next  = wbm_dat_i;
          src_next   = src_reg + 32'd4;
          tmo_next   = '0;
          state_next = ST_RD_GAP;
        end else if (rsp_rty) begin
          retry_next = 1'b1;
          tmo_next   = '0;
          state_next = ST_RD_GAP;
        end else if (tmo_reg == TMO_LAST) begin
          error_next = 1'b1;
          state_next = ST_FIN;
        end else begin
          tmo_next = tmo_reg + TMO_W'(1);
        end
      end

      ST_WR: begin
        if (rsp_err) begin
          error_next = 1'b1;
          state_next = ST_FIN;
        end else if (rsp_ack) begin
          dst_next   = dst_reg + 32'd4;
          cnt_next   = cnt_reg - LEN_W'(1);
          tmo_next   = '0;
          state_next = ST_WR_GAP;
        end else if (rsp_rty) begin
          retry_next = 1'b1;
          tmo_next   = '0;
          state_next = ST_WR_GAP;
        end else if (tmo_reg == TMO_LAST) begin
          error_next = 1'b1;
          state_next = ST_FIN;
        end else begin
          tmo_next = tmo_reg + TMO_W'(1);
        end
      end

      // A retried read is reissued, otherwise the word goes out
      ST_RD_GAP: begin
        retry_next = 1'b0;
        state_next = retry_reg ? ST_RD : ST_WR;
      end

      // A retried write is reissued, otherwise fetch the next word or finish
      ST_WR_GAP: begin
        retry_next = 1'b0;
        if (retry_reg) begin
          state_next = ST_WR;
        end else if (cnt_reg != '0) begin
          state_next = ST_RD;
        end else begin
          state_next = ST_FIN;
        end
      end

      ST_FIN: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, decoded from the next state
  always_comb begin
    adr_next  = '0;
    dat_next  = '0;
    sel_next  = '0;
    we_next   = 1'b0;
    cyc_next  = 1'b0;
    stb_next  = 1'b0;
    busy_next = (state_next != ST_IDLE) && (state_next != ST_FIN);
    done_next = (state_next == ST_FIN);

    if (state_next == ST_RD) begin
      cyc_next = 1'b1;
      stb_next = 1'b1;
      sel_next = SEL_ALL;
      adr_next = {src_next[31:2], 2'b00};
    end else if (state_next == ST_WR) begin
      cyc_next = 1'b1;
      stb_next = 1'b1;
      we_next  = 1'b1;
      sel_next = SEL_ALL;
      adr_next = {dst_next[31:2], 2'b00};
      dat_next = data_next;
    end
  end

  assign wbm_adr_o = adr_reg;
  assign wbm_dat_o = dat_reg;
  assign wbm_sel_o = sel_reg;
  assign wbm_we_o  = we_reg;
  assign wbm_cyc_o = cyc_reg;
  assign wbm_stb_o = stb_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign error     = error_reg;

endmodule : wb_copy_engine

// File: tb/tb_wb_copy_engine.sv
// Directed bench for wb_copy_engine: a scripted Wishbone slave whose read
// data is a function of address, a table of copy scenarios, and hand-written
// sequences for mid-copy reset.
module tb_wb_copy_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] src_adr, dst_adr;
  logic [11:0] len;
  logic        busy, done, error;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
  logic [31:0] s_dat;
  logic        s_ack, s_err, s_rty;

  wb_copy_engine #(.TIMEOUT(16), .LEN_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .src_adr(src_adr), .dst_adr(dst_adr), .len(len),
    .busy(busy), .done(done), .error(error),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_dat_i(s_dat), .wbm_ack_i(s_ack), .wbm_err_i(s_err), .wbm_rty_i(s_rty)
  );

  always #5 clk = ~clk;

  // Slave script (written only by the stimulus process)
  logic [7:0] cur_tag = 8'h00;
  int err_rd  = -1;
  int hang_rd = -1;
  int rty_wr  = -1;
  int rd_base = 0;
  int wr_base = 0;
  int rty_base = 0;

  // Monitor state (written only by the monitor process)
  int cyc_num = 0;
  int stb_total = 0;
  int busy_total = 0;
  int done_total = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int rty_cnt = 0;
  logic [31:0] wlog_adr [256];
  logic [31:0] wlog_dat [256];
  int          wlog_cyc [256];
  logic [31:0] rty_adr, rty_dat;
  int          rty_cyc = 0;

  int n_chk = 0;
  int n_fail = 0;

  function automatic logic [31:0] pat(input logic [31:0] a, input logic [7:0] tag);
    return {tag, 24'h000000} ^ a ^ 32'h005A_C3A5;
  endfunction

  // Slave responses, same cycle as the strobe
  always_comb begin
    s_ack = 1'b0;
    s_err = 1'b0;
    s_rty = 1'b0;
    s_dat = 32'h0;
    if (wbm_cyc_o && wbm_stb_o) begin
      if (!wbm_we_o) begin
        if ((rd_cnt - rd_base) == err_rd) begin
          s_err = 1'b1;
        end else if ((rd_cnt - rd_base) != hang_rd) begin
          s_ack = 1'b1;
          s_dat = pat(wbm_adr_o, cur_tag);
        end
      end else begin
        if (((wr_cnt - wr_base) == rty_wr) && (rty_cnt == rty_base)) s_rty = 1'b1;
        else s_ack = 1'b1;
      end
    end
  end

  // Bus monitor: counts strobe/busy/done cycles and logs completed writes
  always @(posedge clk) begin
    cyc_num <= cyc_num + 1;
    if (wbm_stb_o) stb_total <= stb_total + 1;
    if (busy) busy_total <= busy_total + 1;
    if (done) done_total <= done_total + 1;
    if (wbm_cyc_o && wbm_stb_o && !wbm_we_o && (s_ack || s_err)) rd_cnt <= rd_cnt + 1;
    if (wbm_cyc_o && wbm_stb_o && wbm_we_o && s_ack && wr_cnt < 256) begin
      wlog_adr[wr_cnt] <= wbm_adr_o;
      wlog_dat[wr_cnt] <= wbm_dat_o;
      wlog_cyc[wr_cnt] <= cyc_num;
      wr_cnt <= wr_cnt + 1;
    end
    if (wbm_cyc_o && wbm_stb_o && wbm_we_o && s_rty && !s_ack && !s_err) begin
      rty_adr <= wbm_adr_o;
      rty_dat <= wbm_dat_o;
      rty_cyc <= cyc_num;
      rty_cnt <= rty_cnt + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    int          len;
    logic [31:0] src;
    logic [31:0] dst;
    int          err_rd;
    int          hang_rd;
    int          rty_wr;
    int          spur_at;
    int          exp_cyc;
    int          exp_stb;
    int          exp_wr;
    bit          exp_err;
    bit          exp_busy;
  } vec_t;

  // Runs one copy; must be entered 1 time unit after a rising edge
  task automatic run_vec(input vec_t v, input logic [7:0] tag);
    int cnt;
    int stb0, busy0, wr0;
    bit seen;
    logic [31:0] a;
    cur_tag  = tag;
    err_rd   = v.err_rd;
    hang_rd  = v.hang_rd;
    rty_wr   = v.rty_wr;
    rd_base  = rd_cnt;
    wr_base  = wr_cnt;
    rty_base = rty_cnt;
    wr0   = wr_cnt;
    stb0  = stb_total;
    busy0 = busy_total;
    start   = 1'b1;
    src_adr = v.src;
    dst_adr = v.dst;
    len     = 12'(v.len);
    cnt  = 0;
    seen = 1'b0;
    while (cnt < 200 && !seen) begin
      @(posedge clk);
      cnt++;
      #1;
      if (cnt == v.spur_at) begin
        start   = 1'b1;
        len     = 12'd5;
        src_adr = 32'h7000_0000;
        dst_adr = 32'h7100_0000;
      end else begin
        start = 1'b0;
      end
      if (cnt == 1) chk({v.name, " error_cleared"}, 32'(error), 32'd0);
      seen = done;
    end
    chk({v.name, " done_seen"}, 32'(seen), 32'd1);
    chk({v.name, " cycles"}, 32'(cnt), 32'(v.exp_cyc));
    chk({v.name, " error"}, 32'(error), 32'(v.exp_err));
    chk({v.name, " stb_cycles"}, 32'(stb_total - stb0), 32'(v.exp_stb));
    chk({v.name, " writes"}, 32'(wr_cnt - wr0), 32'(v.exp_wr));
    chk({v.name, " busy_seen"}, 32'((busy_total - busy0) > 0), 32'(v.exp_busy));
    for (int k = 0; k < v.exp_wr && k < (wr_cnt - wr0); k++) begin
      a = {v.dst[31:2], 2'b00} + 32'(4 * k);
      chk($sformatf("%s wr%0d_adr", v.name, k), wlog_adr[wr0 + k], a);
      a = {v.src[31:2], 2'b00} + 32'(4 * k);
      chk($sformatf("%s wr%0d_dat", v.name, k), wlog_dat[wr0 + k], pat(a, tag));
    end
    if (v.rty_wr >= 0) begin
      chk({v.name, " rty_count"}, 32'(rty_cnt - rty_base), 32'd1);
      chk({v.name, " rty_same_adr"}, rty_adr, wlog_adr[wr0 + v.rty_wr]);
      chk({v.name, " rty_same_dat"}, rty_dat, wlog_dat[wr0 + v.rty_wr]);
      chk({v.name, " rty_gap"}, 32'(wlog_cyc[wr0 + v.rty_wr] - rty_cyc), 32'd2);
    end
    @(posedge clk);
    #1;
    chk({v.name, " done_one_cycle"}, 32'(done), 32'd0);
    chk({v.name, " idle_not_busy"}, 32'(busy), 32'd0);
    chk({v.name, " error_held"}, 32'(error), 32'(v.exp_err));
  endtask

  vec_t vecs [8];
  vec_t v_rst;
  vec_t v_after;

  initial begin
    int done0;
    //          name        len src           dst           erd hang rty spur cyc stb wr err busy
    vecs[0] = '{"copy4",    4, 32'h4000_0000, 32'h4001_0000, -1, -1, -1, -1, 17,  8, 4, 1'b0, 1'b1};
    vecs[1] = '{"len0",     0, 32'h4000_0080, 32'h4001_0080, -1, -1, -1, -1,  1,  0, 0, 1'b0, 1'b0};
    vecs[2] = '{"err_rd2",  3, 32'h4000_0100, 32'h4001_0100,  1, -1, -1, -1,  6,  3, 1, 1'b1, 1'b1};
    vecs[3] = '{"timeout",  2, 32'h4000_0180, 32'h4001_0180, -1,  0, -1, -1, 17, 16, 0, 1'b1, 1'b1};
    vecs[4] = '{"rty_wr1",  1, 32'h4000_0300, 32'h4001_0300, -1, -1,  0, -1,  7,  3, 1, 1'b0, 1'b1};
    vecs[5] = '{"wrap",     2, 32'hFFFF_FFFE, 32'hFFFF_FFFD, -1, -1, -1, -1,  9,  4, 2, 1'b0, 1'b1};
    vecs[6] = '{"copy1",    1, 32'h4000_0380, 32'h4001_0380, -1, -1, -1, -1,  5,  2, 1, 1'b0, 1'b1};
    vecs[7] = '{"start_ign",2, 32'h4000_0400, 32'h4001_0400, -1, -1, -1,  4,  9,  4, 2, 1'b0, 1'b1};
    v_after = '{"after_rst",2, 32'h4000_0500, 32'h4001_0500, -1, -1, -1, -1,  9,  4, 2, 1'b0, 1'b1};

    rst_n   = 1'b0;
    start   = 1'b0;
    src_adr = 32'h0;
    dst_adr = 32'h0;
    len     = 12'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst cyc", 32'(wbm_cyc_o), 32'd0);
    chk("rst stb", 32'(wbm_stb_o), 32'd0);
    chk("rst adr", wbm_adr_o, 32'd0);
    chk("rst sel", 32'(wbm_sel_o), 32'd0);
    chk("rst busy_done_error", 32'({busy, done, error}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], 8'(8'h10 + i));
      $display("vector %0d %s: cycles/writes checked, failures so far %0d", i, vecs[i].name, n_fail);
    end

    // Reset asserted in the middle of an 8-word copy
    cur_tag  = 8'h77;
    err_rd   = -1;
    hang_rd  = -1;
    rty_wr   = -1;
    rd_base  = rd_cnt;
    wr_base  = wr_cnt;
    rty_base = rty_cnt;
    start   = 1'b1;
    src_adr = 32'h4000_0200;
    dst_adr = 32'h4001_0200;
    len     = 12'd8;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    done0 = done_total;
    chk("pre_rst busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst cyc", 32'(wbm_cyc_o), 32'd0);
    chk("midrst stb", 32'(wbm_stb_o), 32'd0);
    chk("midrst we", 32'(wbm_we_o), 32'd0);
    chk("midrst sel", 32'(wbm_sel_o), 32'd0);
    chk("midrst adr", wbm_adr_o, 32'd0);
    chk("midrst dat", wbm_dat_o, 32'd0);
    chk("midrst busy_done_error", 32'({busy, done, error}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("midrst no_done", 32'(done_total - done0), 32'd0);
    rst_n = 1'b1;
    run_vec(v_after, 8'h88);
    $display("reset sequence: mid-copy reset and restart checked, failures so far %0d", n_fail);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_wb_copy_engine
